// File: rtl/ram_writer.sv
// Store-to-memory writer.
// Takes one byte, halfword or word store at an arbitrary byte address and
// turns it into one or two word-wide memory writes with byte-lane enables.
// A store that crosses a word boundary is issued as two back-to-back
// writes: the low word first, then the next word address, which wraps.
// All memory-side outputs are registered, so the first write appears in
// the cycle after the request handshake.
module ram_writer #(
    parameter int AWIDTH = 17,
    parameter int DWIDTH = 32   // only 32 is supported
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Registered memory-side outputs and their next values
    logic              mem_we_reg,    mem_we_next;
    logic [AWIDTH-1:0] mem_addr_reg,  mem_addr_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;
    logic [3:0]        mem_be_reg,    mem_be_next;
    logic              done_reg,      done_next;
    logic              err_reg,       err_next;

    // Upper half of a split store, precomputed when the request is accepted
    logic              split_reg;
    logic [AWIDTH-1:0] hi_addr_reg;
    logic [31:0]       hi_wdata_reg;
    logic [3:0]        hi_be_reg;
    logic              capture;

    // Request decode: offset, byte mask, word address and lane placement
    logic [1:0]        req_off;
    logic [3:0]        req_mask;
    logic [AWIDTH-1:0] req_word;
    logic [7:0]        lane_be;
    logic [63:0]       lane_data;
    logic              req_split;

    assign req_off   = req_addr[1:0];
    assign req_word  = req_addr[AWIDTH+1:2];
    assign lane_be   = {4'b0000, req_mask} << req_off;
    assign lane_data = {32'h0000_0000, req_data} << {req_off, 3'b000};
    assign req_split = (lane_be[7:4] != 4'b0000);

    // Address bits above the word address are deliberately ignored
    generate
        if (AWIDTH + 2 < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[31:AWIDTH+2];
        end
    endgenerate

    // Byte mask for the access size; the illegal size gets no lanes
    always_comb begin
        req_mask = 4'b0000;
        case (req_size)
            2'b00:   req_mask = 4'b0001;
            2'b01:   req_mask = 4'b0011;
            2'b10:   req_mask = 4'b1111;
            default: req_mask = 4'b0000;
        endcase
    end

    // Ready only while idle and not held in reset
    assign req_ready = (state_reg == IDLE) && !reset;

    // Next-state and next-output logic; addr/wdata hold unless a write is issued
    always_comb begin
        state_next     = state_reg;
        mem_we_next    = 1'b0;
        mem_be_next    = 4'b0000;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        capture        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_size == 2'b11) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else begin
                        state_next     = WR_LO;
                        capture        = 1'b1;
                        mem_we_next    = 1'b1;
                        mem_addr_next  = req_word;
                        mem_be_next    = lane_be[3:0];
                        mem_wdata_next = lane_data[31:0];
                        done_next      = !req_split;
                    end
                end
            end
            WR_LO: begin
                if (split_reg) begin
                    state_next     = WR_HI;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = hi_addr_reg;
                    mem_be_next    = hi_be_reg;
                    mem_wdata_next = hi_wdata_reg;
                    done_next      = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            WR_HI:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, output and split-half registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= 4'b0000;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            split_reg     <= 1'b0;
            hi_addr_reg   <= '0;
            hi_wdata_reg  <= '0;
            hi_be_reg     <= 4'b0000;
        end else begin
            state_reg     <= state_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_be_reg    <= mem_be_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            if (capture) begin
                split_reg    <= req_split;
                hi_addr_reg  <= req_word + {{(AWIDTH-1){1'b0}}, 1'b1};
                hi_wdata_reg <= lane_data[63:32];
                hi_be_reg    <= lane_be[7:4];
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_ram_writer.sv
// Directed bench for ram_writer with a 3-bit word address so that
// wraparound of a split store can be exercised.
module tb_ram_writer;

    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_size;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    ram_writer #(.AWIDTH(AW), .DWIDTH(32)) dut (
        .clock     (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Check every output of the writer in one call
    task automatic chk_all(input string tag, input logic rdy, input logic we,
                           input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic dn, input logic er);
        chk({tag, ".ready"}, {31'b0, req_ready}, {31'b0, rdy});
        chk({tag, ".we"},    {31'b0, mem_we},    {31'b0, we});
        chk({tag, ".addr"},  {29'b0, mem_addr},  addr);
        chk({tag, ".be"},    {28'b0, mem_be},    {28'b0, be});
        chk({tag, ".wdata"}, mem_wdata,          wdata);
        chk({tag, ".done"},  {31'b0, done},      {31'b0, dn});
        chk({tag, ".err"},   {31'b0, err},       {31'b0, er});
        $display("step %s: ready=%0b we=%0b addr=%0d be=%b wdata=%08h done=%0b err=%0b",
                 tag, req_ready, mem_we, mem_addr, mem_be, mem_wdata, done, err);
    endtask

    // Present one request for a single edge, then drive junk to prove capture
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_data  = 32'h5555_5555;
        req_size  = 2'b10;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0010;
        req_data  = 32'h1111_1111;
        req_size  = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 1'b0, 1'b0, 32'd0, 4'h0, 32'h0, 1'b0, 1'b0);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk_all("post_reset", 1'b1, 1'b0, 32'd0, 4'h0, 32'h0, 1'b0, 1'b0);

        // Aligned word store
        send(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
        chk_all("word", 1'b0, 1'b1, 32'd4, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("word_idle", 1'b1, 1'b0, 32'd4, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Byte store in the top lane
        send(32'h0000_0007, 32'h0000_00AB, 2'b00);
        chk_all("byte", 1'b0, 1'b1, 32'd1, 4'b1000, 32'hAB00_0000, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("byte_idle", 1'b1, 1'b0, 32'd1, 4'b0000, 32'hAB00_0000, 1'b0, 1'b0);

        // Halfword at offset 1 stays within one word
        send(32'h0000_0009, 32'h0000_1234, 2'b01);
        chk_all("half_o1", 1'b0, 1'b1, 32'd2, 4'b0110, 32'h0012_3400, 1'b1, 1'b0);
        @(negedge clk);

        // Split word store across words 1 and 2
        send(32'h0000_0006, 32'h4433_2211, 2'b10);
        chk_all("split_lo", 1'b0, 1'b1, 32'd1, 4'b1100, 32'h2211_0000, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("split_hi", 1'b0, 1'b1, 32'd2, 4'b0011, 32'h0000_4433, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("split_idle", 1'b1, 1'b0, 32'd2, 4'b0000, 32'h0000_4433, 1'b0, 1'b0);

        // Split halfword at the last word wraps to word 0; high address bits ignored
        send(32'hFFFF_FF1F, 32'h0000_BBAA, 2'b01);
        chk_all("wrap_lo", 1'b0, 1'b1, 32'd7, 4'b1000, 32'hAA00_0000, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("wrap_hi", 1'b0, 1'b1, 32'd0, 4'b0001, 32'h0000_00BB, 1'b1, 1'b0);
        @(negedge clk);

        // Illegal size produces a single err pulse and no write
        send(32'h0000_0000, 32'hCAFE_F00D, 2'b11);
        chk_all("illegal", 1'b0, 1'b0, 32'd0, 4'b0000, 32'h0000_00BB, 1'b0, 1'b1);
        @(negedge clk);
        chk_all("illegal_idle", 1'b1, 1'b0, 32'd0, 4'b0000, 32'h0000_00BB, 1'b0, 1'b0);

        // Reset during the low half of a split store cancels the high half
        send(32'h0000_0006, 32'h4433_2211, 2'b10);
        chk_all("abort_lo", 1'b0, 1'b1, 32'd1, 4'b1100, 32'h2211_0000, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_all("abort_rst", 1'b0, 1'b0, 32'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk_all("abort_idle", 1'b1, 1'b0, 32'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
        send(32'h0000_0002, 32'h0000_005A, 2'b00);
        chk_all("after_abort", 1'b0, 1'b1, 32'd0, 4'b0100, 32'h005A_0000, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("after_abort_idle", 1'b1, 1'b0, 32'd0, 4'b0000, 32'h005A_0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
